// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and state encodings for the pipeline stall controller
// and the mult/div busy tracker.
package pipe_stall_ctrl_pkg;
  localparam int REG_W       = 5;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;
endpackage

// File: rtl/pipe_stall_ctrl_md_busy_fsm.sv
// Tracks the multi-cycle mult/div unit: a start loads a down-counter and
// o_busy stays high until the counter reaches its terminal count.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MD_IDLE | unit free; a start loads the counter with the op latency
//   MD_BUSY | unit computing; counter runs down, exit after count of 1
module md_busy_fsm #(
  parameter int MULT_CYCLES = pipe_stall_ctrl_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = pipe_stall_ctrl_pkg::DIV_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy
);
  import pipe_stall_ctrl_pkg::*;

  localparam int MAX_N = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW    = $clog2(MAX_N + 1);

  md_state_t       r_state;
  logic [CW-1:0]   r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_state <= MD_BUSY;
            r_cnt   <= i_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end
        end
        MD_BUSY: begin
          // a start seen here is ignored: the unit cannot be restarted mid-op
          if (r_cnt == CW'(1)) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy = (r_state == MD_BUSY);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: load-use and HI/LO
// mult/div interlocks, pipeline register enables, and a stall cycle counter.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = pipe_stall_ctrl_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = pipe_stall_ctrl_pkg::DIV_CYCLES,
  parameter int CNT_W       = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [pipe_stall_ctrl_pkg::REG_W-1:0] id_rs,
  input  logic [pipe_stall_ctrl_pkg::REG_W-1:0] id_rt,
  input  logic                                 id_use_rs,
  input  logic                                 id_use_rt,
  input  logic                                 id_is_md,
  input  logic                                 ex_is_load,
  input  logic [pipe_stall_ctrl_pkg::REG_W-1:0] ex_wa,
  input  logic                                 ex_md_start,
  input  logic                                 ex_md_div,
  output logic                                 pc_en,
  output logic                                 en_fd,
  output logic                                 en_de,
  output logic                                 clr_de,
  output logic                                 en_em,
  output logic                                 en_mw,
  output logic                                 md_busy,
  output logic [CNT_W-1:0]                     stall_cnt
);
  import pipe_stall_ctrl_pkg::*;

  logic             w_load_use;
  logic             w_md_stall;
  logic             w_stall;
  logic             w_md_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  md_busy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_fsm (
    .clk     (clk),
    .rst_n   (reset),
    .i_start (ex_md_start),
    .i_div   (ex_md_div),
    .o_busy  (w_md_busy)
  );

  // $0 is hardwired, so a load targeting it never creates a dependency
  assign w_load_use = ex_is_load && (ex_wa != '0) &&
                      ((id_use_rs && (id_rs == ex_wa)) ||
                       (id_use_rt && (id_rt == ex_wa)));
  assign w_md_stall = id_is_md && (w_md_busy || ex_md_start);
  assign w_stall    = w_load_use || w_md_stall;

  // IF/ID hold on a stall while a bubble is pushed into EX and later stages drain
  assign pc_en   = reset && !w_stall;
  assign en_fd   = reset && !w_stall;
  assign en_de   = reset;
  assign clr_de  = reset && w_stall;
  assign en_em   = reset;
  assign en_mw   = reset;
  assign md_busy = w_md_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;
  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_wa;
  logic        id_use_rs, id_use_rt, id_is_md, ex_is_load, ex_md_start, ex_md_div;
  logic        pc_en, en_fd, en_de, clr_de, en_em, en_mw, md_busy;
  logic [15:0] stall_cnt;
  logic [6:0]  ctrl;

  int compared   = 0;
  int mismatched = 0;
  int m_rem      = 0;  // busy cycles still to run in the mult/div unit
  int m_cnt      = 0;  // expected stall count

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_md(id_is_md), .ex_is_load(ex_is_load), .ex_wa(ex_wa),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .clr_de(clr_de),
    .en_em(en_em), .en_mw(en_mw), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  assign ctrl = {pc_en, en_fd, en_de, clr_de, en_em, en_mw, md_busy};

  function automatic logic exp_stall();
    logic lu;
    lu = ex_is_load && (ex_wa != 5'd0) &&
         ((id_use_rs && id_rs == ex_wa) || (id_use_rt && id_rt == ex_wa));
    return lu || (id_is_md && (m_rem > 0 || ex_md_start));
  endfunction

  function automatic logic [6:0] exp_ctrl();
    logic s;
    if (!reset) return 7'b0;
    s = exp_stall();
    return {!s, !s, 1'b1, s, 1'b1, 1'b1, (m_rem > 0)};
  endfunction

  // Advance one clock and update the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_rem = 0;
      m_cnt = 0;
    end else begin
      if (exp_stall()) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (ex_md_start) m_rem = ex_md_div ? 10 : 5;
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_wa = 0;
    id_use_rs = 0; id_use_rt = 0; id_is_md = 0;
    ex_is_load = 0; ex_md_start = 0; ex_md_div = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    ex_md_start = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    compared++;
    if (ctrl !== 7'b0) begin
      mismatched++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 7'b0);
    end
    compared++;
    if (stall_cnt !== 16'd0) begin
      mismatched++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt);
    end
    tick();
    reset = 1'b1;
    ex_md_start = 1'b0;
    @(negedge clk);
    compared++;
    if (ctrl !== 7'b1110110) begin
      mismatched++; $display("FAIL reset_release got=%b exp=%b", ctrl, 7'b1110110);
    end
  endtask

  task automatic test_load_use();
    tick();
    clear_inputs();
    ex_is_load = 1; ex_wa = 8; id_rs = 8; id_use_rs = 1;
    @(negedge clk);
    compared++;
    if (ctrl !== 7'b0011110 || ctrl !== exp_ctrl()) begin
      mismatched++; $display("FAIL load_use_rs got=%b exp=%b", ctrl, 7'b0011110);
    end
    tick();
    ex_wa = 0; id_rs = 0;
    @(negedge clk);
    compared++;
    if (ctrl !== 7'b1110110) begin
      mismatched++; $display("FAIL load_use_r0 got=%b exp=%b", ctrl, 7'b1110110);
    end
    compared++;
    if (stall_cnt !== 16'(m_cnt)) begin
      mismatched++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, m_cnt);
    end
  endtask

  task automatic test_rt_only();
    tick();
    clear_inputs();
    ex_is_load = 1; ex_wa = 9; id_rt = 9; id_rs = 9; id_use_rt = 1; id_use_rs = 0;
    @(negedge clk);
    compared++;
    if (ctrl !== 7'b0011110) begin
      mismatched++; $display("FAIL rt_hazard got=%b exp=%b", ctrl, 7'b0011110);
    end
    tick();
    id_use_rt = 0;
    @(negedge clk);
    compared++;
    if (ctrl !== 7'b1110110) begin
      mismatched++; $display("FAIL rt_unused got=%b exp=%b", ctrl, 7'b1110110);
    end
  endtask

  task automatic test_mult();
    int base;
    tick();
    clear_inputs();
    id_is_md = 1; ex_md_start = 1; ex_md_div = 0;
    base = m_cnt;
    @(negedge clk);
    compared++;
    if (ctrl !== 7'b0011110) begin
      mismatched++; $display("FAIL mult_start got=%b exp=%b", ctrl, 7'b0011110);
    end
    tick();
    ex_md_start = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      compared++;
      if (md_busy !== (k <= 5) || pc_en !== (k == 6) || ctrl !== exp_ctrl()) begin
        mismatched++;
        $display("FAIL mult_cycle%0d got=%b exp=%b", k, ctrl, exp_ctrl());
      end
      tick();
    end
    compared++;
    if (stall_cnt !== 16'(base + 6)) begin
      mismatched++; $display("FAIL mult_cnt got=%0d exp=%0d", stall_cnt, base + 6);
    end
    id_is_md = 0;
  endtask

  task automatic test_div();
    int busy_cycles;
    busy_cycles = 0;
    tick();
    clear_inputs();
    ex_md_start = 1; ex_md_div = 1;
    @(negedge clk);
    compared++;
    if (ctrl !== 7'b1110110) begin
      mismatched++; $display("FAIL div_start got=%b exp=%b", ctrl, 7'b1110110);
    end
    tick();
    ex_md_start = 0;
    for (int k = 1; k <= 12; k++) begin
      ex_md_start = (k == 3);
      ex_md_div = 0;
      @(negedge clk);
      if (md_busy === 1'b1) busy_cycles++;
      compared++;
      if (md_busy !== (k <= 10) || ctrl !== exp_ctrl()) begin
        mismatched++;
        $display("FAIL div_cycle%0d got=%b exp=%b", k, ctrl, exp_ctrl());
      end
      tick();
    end
    ex_md_start = 0;
    compared++;
    if (busy_cycles != 10) begin
      mismatched++; $display("FAIL div_busy_len got=%0d exp=10", busy_cycles);
    end
  endtask

  task automatic test_reset_mid_div();
    tick();
    clear_inputs();
    ex_md_start = 1; ex_md_div = 1;
    tick();
    ex_md_start = 0;
    repeat (3) tick();
    @(negedge clk);
    compared++;
    if (md_busy !== 1'b1) begin
      mismatched++; $display("FAIL middiv_busy got=%b exp=1", md_busy);
    end
    #2;
    reset = 1'b0;
    m_rem = 0;
    m_cnt = 0;
    #1;
    compared++;
    if (ctrl !== 7'b0 || stall_cnt !== 16'd0) begin
      mismatched++; $display("FAIL middiv_async got=%b/%0d exp=0000000/0", ctrl, stall_cnt);
    end
    tick();
    reset = 1'b1;
    id_is_md = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      compared++;
      if (ctrl !== 7'b1110110) begin
        mismatched++; $display("FAIL middiv_after%0d got=%b exp=%b", k, ctrl, 7'b1110110);
      end
      tick();
    end
    id_is_md = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick();
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_wa       = 5'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom);
      id_use_rt   = 1'($urandom);
      id_is_md    = 1'($urandom);
      ex_is_load  = 1'($urandom);
      ex_md_start = ($urandom_range(0, 7) == 0);
      ex_md_div   = 1'($urandom);
      @(negedge clk);
      compared++;
      if (ctrl !== exp_ctrl()) begin
        mismatched++; $display("FAIL rand_ctrl i=%0d got=%b exp=%b", i, ctrl, exp_ctrl());
      end
      compared++;
      if (stall_cnt !== 16'(m_cnt)) begin
        mismatched++; $display("FAIL rand_cnt i=%0d got=%0d exp=%0d", i, stall_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    tick();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ex_is_load = 1; ex_wa = 3; id_rs = 3; id_use_rs = 1;
    repeat (65536 + 5) tick();
    @(negedge clk);
    compared++;
    if (stall_cnt !== 16'hFFFF || stall_cnt !== 16'(m_cnt)) begin
      mismatched++; $display("FAIL saturate got=%0d exp=%0d", stall_cnt, 65535);
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_rt_only();
    test_mult();
    test_div();
    test_reset_mid_div();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Hazard and stall controller for the five-stage pipeline. It drives the enable and bubble-insert controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC write enable. It detects load-use hazards. It also tracks the multi-cycle mult/div unit with a busy state machine, so that HI/LO instructions in ID wait until the unit is idle. A saturating performance counter records the number of stalled cycles.

Parameters:
MULT_CYCLES, 5, number of busy cycles after a mult/multu start
DIV_CYCLES, 10, number of busy cycles after a div/divu start
CNT_W, 16, width of the stall performance counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
id_rs  input  5  rs field of the instruction in ID
id_rt  input  5  rt field of the instruction in ID
id_use_rs  input  1  the ID instruction reads rs in ID or EX
id_use_rt  input  1  the ID instruction reads rt in ID or EX
id_is_md  input  1  the ID instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
ex_is_load  input  1  the EX instruction is a load (lw/lh/lhu/lb/lbu)
ex_wa  input  5  destination register of the EX instruction
ex_md_start  input  1  the EX instruction starts the mult/div unit this cycle
ex_md_div  input  1  qualifies ex_md_start: 1 = div/divu, 0 = mult/multu
pc_en  output  1  PC write enable
en_fd  output  1  IF/ID register enable
en_de  output  1  ID/EX register enable
clr_de  output  1  ID/EX synchronous clear (bubble insertion)
en_em  output  1  EX/MEM register enable
en_mw  output  1  MEM/WB register enable
md_busy  output  1  the mult/div unit is computing
stall_cnt  output  CNT_W  number of stalled cycles since reset (saturating)

Behaviour:
- Reset (reset=0, asynchronous): md_state=IDLE, md_cnt=0, stall_cnt=0, md_busy=0.
- While reset=0, the outputs are also forced: pc_en=en_fd=en_de=en_em=en_mw=0 and clr_de=0.
- load_use = ex_is_load & (ex_wa!=0) & ((id_use_rs & id_rs==ex_wa) | (id_use_rt & id_rt==ex_wa)).
- md_stall = id_is_md & (md_busy | ex_md_start).
- stall = load_use | md_stall. It is combinational from the inputs and the current state, with no added latency.
- When stall=1: pc_en=0, en_fd=0, en_de=1, clr_de=1, en_em=1, en_mw=1. IF and ID hold; a bubble enters EX; later stages drain.
- When stall=0: pc_en=en_fd=en_de=en_em=en_mw=1 and clr_de=0.
- The load-use hazard is never raised when ex_wa is $0. Both source operands are checked, and a match on either stalls.
- Mult/div FSM, states IDLE and BUSY:
  - IDLE: if ex_md_start=1, load md_cnt with DIV_CYCLES when ex_md_div=1, otherwise MULT_CYCLES, and go to BUSY.
  - BUSY: md_cnt decrements each cycle. When md_cnt==1, return to IDLE at the next edge (md_cnt becomes 0).
  - md_busy=1 exactly when the state is BUSY.
- Timing: with a start at edge cycle t, md_busy is high for cycles t+1 .. t+N, where N is MULT_CYCLES or DIV_CYCLES.
- Stall of a dependent HI/LO instruction: it stalls in cycle t (via ex_md_start) and in cycles t+1 .. t+N. It proceeds in cycle t+N+1.
- An ex_md_start that arrives in BUSY is ignored: no restart, and the counter is unchanged. This cannot occur in legal operation.
- A non-MD instruction in ID never stalls on md_busy.
- Simultaneous load_use and md_stall: stall once; there is no double counting.
- stall_cnt increments by 1 on each edge where stall=1 and reset=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted in the middle of BUSY: the FSM returns to IDLE immediately, md_busy=0 with no clock edge needed, and the count is discarded.
- The block is fully synchronous apart from the reset.

Decomposition:
- Shared package/header:
  - the MD_IDLE/MD_BUSY state encodings;
  - the MULT_CYCLES and DIV_CYCLES defaults, which the mult/div unit uses as well;
  - the register-address width constant REG_W=5.
- One natural sub-module, md_busy_fsm. It holds the IDLE/BUSY state and the down-counter, takes ex_md_start and ex_md_div, and outputs md_busy.
- The hazard equations, control outputs and stall counter stay at the top level.

Test Plan:
- Reset: hold reset=0 for 3 cycles with ex_md_start=1 → all enables 0, md_busy=0, stall_cnt=0. Release reset → enables 1, clr_de=0.
- Load-use: ex_is_load=1, ex_wa=8, id_rs=8, id_use_rs=1 → pc_en=0, en_fd=0, clr_de=1 for that cycle. Change ex_wa to 0 → no stall.
- Rt-only hazard: id_rt=9, id_use_rt=1, id_use_rs=0, ex_wa=9, load → stall. The same setup with id_use_rt=0 → no stall.
- Mult: ex_md_start=1, ex_md_div=0 at cycle t, with id_is_md=1 held → md_busy high for cycles t+1..t+5; stall in cycles t..t+5; pc_en=1 at cycle t+6. stall_cnt=6.
- Div: start with ex_md_div=1 → md_busy high for exactly 10 cycles. A second ex_md_start at busy cycle 3 → ignored, and busy still ends after 10 cycles. With id_is_md=0 throughout → no stall.
- Reset mid-div at busy cycle 4 (reset driven low between edges) → md_busy drops immediately. After release, id_is_md=1 → no stall. Separately, force stall=1 for 2^16+5 cycles → stall_cnt=65535.
